// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types for the bit-serial arithmetic units
package arith_pkg;

  // Control states of the serial subtractor handshake
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : arith_pkg

// File: rtl/onebit_full_adder.sv
// rtl/onebit_full_adder.sv - single-bit full adder cell
module onebit_full_adder (
  input  logic x,
  input  logic y,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  // Plain combinational full add of one bit column
  always_comb begin
    sum      = x ^ y ^ carryin;
    carryout = (x & y) | ((x ^ y) & carryin);
  end

endmodule : onebit_full_adder

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - bin behind a start/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             borrowout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             nb0;
  logic             fa_sum;
  logic             fa_carry;

  // Subtraction is addition of the inverted subtrahend; the carry seed ~bin
  // supplies the +1 of the two's complement minus the borrow in.
  assign nb0 = ~b_q[0];

  onebit_full_adder u_fa (
    .x        (a_q[0]),
    .y        (nb0),
    .carryin  (c_q),
    .sum      (fa_sum),
    .carryout (fa_carry)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operand shifters, carry, counter and held results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update; results only change on the final bit so
  // the outputs hold steady from one DONE to the next.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = ~bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = fa_carry;
        res_d = {fa_sum, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // c_q is the carry into the MSB column, fa_carry the carry out of it
          diff_d   = {fa_sum, res_q[WIDTH-1:1]};
          borrow_d = ~fa_carry;
          ovf_d    = c_q ^ fa_carry;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready     = (state_q != SHIFT);
  assign done      = (state_q == DONE);
  assign Diff      = diff_q;
  assign borrowout = borrow_q;
  assign overflow  = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         bin;
  logic         ready;
  logic         done;
  logic [W-1:0] Diff;
  logic         borrowout;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  logic [W-1:0] last_diff = '0;
  logic         last_bo = 1'b0;
  logic         last_ov = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .ready     (ready),
    .done      (done),
    .Diff      (Diff),
    .borrowout (borrowout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: {overflow, borrow, diff} of A - B - bin
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    logic [W:0] full;
    int         sa, sb, r;
    logic       ov;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    r    = sa - sb - int'({31'b0, bi});
    ov   = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Monitor: pop and compare on every done pulse, check hold between pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      last_diff = '0;
      last_bo   = 1'b0;
      last_ov   = 1'b0;
    end else if (done) begin
      n_done++;
      chk("ready_in_done", ready, 1);
      if (exp_q.size() == 0) begin
        chk("done_with_pending_op", exp_q.size(), 1);
      end else begin
        logic [W+1:0] e;
        int           ac;
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        chk("diff", Diff, e[W-1:0]);
        chk("borrowout", borrowout, e[W]);
        chk("overflow", overflow, e[W+1]);
        chk("latency", cyc - ac, W);
      end
      last_diff = Diff;
      last_bo   = borrowout;
      last_ov   = overflow;
    end else begin
      chk("result_hold", {overflow, borrowout, Diff}, {last_ov, last_bo, last_diff});
    end
  end

  // Issue one operation; call and return at a negedge
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                    input bit hold);
    int t = 0;
    while (ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_wait", ready, 1);
    A     = a;
    B     = b;
    bin   = bi;
    start = 1'b1;
    exp_q.push_back(model(a, b, bi));
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    @(negedge clk);
    if (!hold) start = 1'b0;
    A   = W'($urandom);
    B   = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_borrow", borrowout, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    op(4'd9, 4'd3, 1'b0, 1'b0);
    op(4'd3, 4'd9, 1'b0, 1'b0);
    op(4'd0, 4'd0, 1'b1, 1'b1);
    op(4'd8, 4'd1, 1'b0, 1'b0);
    op(4'd7, 4'd7, 1'b0, 1'b0);
    drain();

    // Start while busy is ignored
    d0 = n_done;
    op(4'd5, 4'd2, 1'b0, 1'b0);
    chk("ready_shift0", ready, 0);
    @(negedge clk);
    chk("ready_shift1", ready, 0);
    @(negedge clk);
    chk("ready_shift2", ready, 0);
    start = 1'b1;
    A     = 4'd0;
    B     = 4'd0;
    @(negedge clk);
    chk("ready_shift3", ready, 0);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("one_done_pulse", n_done - d0, 1);

    // Reset mid-SHIFT aborts with no done pulse
    d0 = n_done;
    op(4'd12, 4'd4, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_diff", Diff, 0);
    chk("abort_borrow", borrowout, 0);
    chk("abort_ovf", overflow, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    repeat (8) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    op(4'd12, 4'd4, 1'b0, 1'b0);
    drain();

    // Exhaustive sweep, issued back-to-back
    for (int bi = 0; bi < 2; bi++) begin
      for (int a = 0; a < (1 << W); a++) begin
        for (int b = 0; b < (1 << W); b++) begin
          op(W'(a), W'(b), 1'(bi), 1'b0);
        end
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor
